// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states,
// default sizing and small op-classification helpers.
package muldiv_unit_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int MUL_ITERS_DEF = 32;
  localparam int DIV_ITERS_DEF = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MADD  = 3'd2,
    OP_MADDU = 3'd3,
    OP_DIV   = 3'd4,
    OP_DIVU  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_e;

  function automatic logic op_is_signed(input muldiv_op_e op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_madd(input muldiv_op_e op);
    return (op == OP_MADD) || (op == OP_MADDU);
  endfunction

endpackage

// File: rtl/muldiv_unit_datapath.sv
// Iterative shift-add multiply / restoring divide on operand magnitudes,
// with the result sign (and optional accumulate) applied in a final pass.
module muldiv_unit_datapath
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int MUL_ITERS = MUL_ITERS_DEF,
  parameter int DIV_ITERS = DIV_ITERS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  muldiv_op_e        op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic [2*XLEN-1:0] acc,
  output logic              last,
  output logic [XLEN-1:0]   res_hi,
  output logic [XLEN-1:0]   res_lo
);

  localparam int MAX_ITERS = (MUL_ITERS > DIV_ITERS) ? MUL_ITERS : DIV_ITERS;
  localparam int CNT_W     = $clog2(MAX_ITERS) + 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_ITERS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITERS - 1);

  logic [2*XLEN-1:0] work_r, work_next_s, acc_r, prod_s;
  logic [XLEN-1:0]   operand_r, mag_a_s, mag_b_s, quot_s, rem_s;
  logic [XLEN:0]     sum_s, diff_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              is_div_r, neg_res_r, neg_rem_r;
  logic              sign_a_s, sign_b_s;

  assign sign_a_s = op_is_signed(op) && a[XLEN-1];
  assign sign_b_s = op_is_signed(op) && b[XLEN-1];
  assign mag_a_s  = sign_a_s ? -a : a;
  assign mag_b_s  = sign_b_s ? -b : b;

  // Multiply adds into the upper half; divide trials the shifted remainder against the divisor
  assign sum_s  = {1'b0, work_r[2*XLEN-1:XLEN]} + {1'b0, operand_r};
  assign diff_s = {work_r[2*XLEN-1:XLEN], work_r[XLEN-1]} - {1'b0, operand_r};

  // One multiply or divide iteration on the shared work register
  always_comb begin
    work_next_s = work_r;
    if (is_div_r) begin
      if (!diff_s[XLEN]) begin
        work_next_s = {diff_s[XLEN-1:0], work_r[XLEN-2:0], 1'b1};
      end else begin
        work_next_s = {work_r[2*XLEN-2:0], 1'b0};
      end
    end else begin
      if (work_r[0]) begin
        work_next_s = {sum_s, work_r[XLEN-1:1]};
      end else begin
        work_next_s = {1'b0, work_r[2*XLEN-1:1]};
      end
    end
  end

  // Operand capture at acceptance, then one iteration per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_r    <= {(2*XLEN){1'b0}};
      acc_r     <= {(2*XLEN){1'b0}};
      operand_r <= {XLEN{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
    end else if (load) begin
      cnt_r     <= {CNT_W{1'b0}};
      is_div_r  <= op_is_div(op);
      neg_res_r <= sign_a_s ^ sign_b_s;
      neg_rem_r <= sign_a_s;
      acc_r     <= op_is_madd(op) ? acc : {(2*XLEN){1'b0}};
      if (op_is_div(op)) begin
        work_r    <= {{XLEN{1'b0}}, mag_a_s};
        operand_r <= mag_b_s;
      end else begin
        work_r    <= {{XLEN{1'b0}}, mag_b_s};
        operand_r <= mag_a_s;
      end
    end else if (step) begin
      work_r <= work_next_s;
      cnt_r  <= cnt_r + CNT_W'(1);
    end
  end

  assign last = (cnt_r == (is_div_r ? DIV_LAST : MUL_LAST));

  // Sign correction: the remainder follows the dividend, everything else the XOR of signs
  assign prod_s = (neg_res_r ? -work_r : work_r) + acc_r;
  assign quot_s = neg_res_r ? -work_r[XLEN-1:0] : work_r[XLEN-1:0];
  assign rem_s  = neg_rem_r ? -work_r[2*XLEN-1:XLEN] : work_r[2*XLEN-1:XLEN];

  assign res_hi = is_div_r ? rem_s  : prod_s[2*XLEN-1:XLEN];
  assign res_lo = is_div_r ? quot_s : prod_s[XLEN-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide responder owning the architectural HI/LO registers.
// Holds the control FSM and handshake; iteration work lives in the datapath.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int MUL_ITERS = MUL_ITERS_DEF,
  parameter int DIV_ITERS = DIV_ITERS_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  muldiv_state_e   state_r, state_next_s;
  muldiv_op_e      op_s;
  logic            accept_s, step_s, dp_load_s, dp_last_s;
  logic            done_next_s, dbz_next_s;
  logic [XLEN-1:0] hi_next_s, lo_next_s, dp_hi_s, dp_lo_s;

  assign op_s     = muldiv_op_e'(req_op);
  assign accept_s = req_valid && req_ready && !flush;
  assign step_s   = (state_r == ST_MUL) || (state_r == ST_DIV);

  // Next state, datapath load and the HI/LO update for this edge
  always_comb begin
    state_next_s = state_r;
    done_next_s  = 1'b0;
    dbz_next_s   = 1'b0;
    dp_load_s    = 1'b0;
    hi_next_s    = hi;
    lo_next_s    = lo;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (op_s)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU: begin
              state_next_s = ST_MUL;
              dp_load_s    = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              if (req_b == {XLEN{1'b0}}) begin
                state_next_s = ST_DONE;
                done_next_s  = 1'b1;
                dbz_next_s   = 1'b1;
                hi_next_s    = req_a;
                lo_next_s    = {XLEN{1'b1}};
              end else begin
                state_next_s = ST_DIV;
                dp_load_s    = 1'b1;
              end
            end
            OP_MTHI: begin
              hi_next_s   = req_a;
              done_next_s = 1'b1;
            end
            OP_MTLO: begin
              lo_next_s   = req_a;
              done_next_s = 1'b1;
            end
            default: done_next_s = 1'b1;
          endcase
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (flush) begin
          state_next_s = ST_IDLE;
        end else if (dp_last_s) begin
          state_next_s = ST_FIX;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_FIX: begin
        if (flush) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
          done_next_s  = 1'b1;
          hi_next_s    = dp_hi_s;
          lo_next_s    = dp_lo_s;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered outputs; ready stays low through the done cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi          <= {XLEN{1'b0}};
      lo          <= {XLEN{1'b0}};
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      hi          <= hi_next_s;
      lo          <= lo_next_s;
      req_ready   <= (state_next_s == ST_IDLE) && !done_next_s;
      busy        <= (state_next_s != ST_IDLE);
      done        <= done_next_s;
      div_by_zero <= dbz_next_s;
    end
  end

  muldiv_unit_datapath #(
    .XLEN      (XLEN),
    .MUL_ITERS (MUL_ITERS),
    .DIV_ITERS (DIV_ITERS)
  ) u_datapath (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (dp_load_s),
    .step   (step_s),
    .op     (op_s),
    .a      (req_a),
    .b      (req_b),
    .acc    ({hi, lo}),
    .last   (dp_last_s),
    .res_hi (dp_hi_s),
    .res_lo (dp_lo_s)
  );

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic/timeline reference model
// compared every cycle, plus directed vectors with hand-computed results.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MADD  = 3'd2;
  localparam logic [2:0] OP_MADDU = 3'd3;
  localparam logic [2:0] OP_DIV   = 3'd4;
  localparam logic [2:0] OP_DIVU  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;
  localparam int LONG_LAT = 34;

  logic        clk, rst_n, req_valid, req_ready, flush, busy, done, div_by_zero;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b, hi, lo;

  int n_pass = 0;
  int n_total = 0;
  logic chk_en = 1'b0;

  muldiv_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  // Reference result {div_by_zero, hi, lo} from plain integer arithmetic
  function automatic logic [64:0] model_exec(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb, q, rm;
    logic [63:0] r;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      OP_MULT:  begin r = sa * sb; return {1'b0, r}; end
      OP_MULTU: begin r = {32'd0, a} * {32'd0, b}; return {1'b0, r}; end
      OP_MADD:  begin r = 64'(sa * sb) + acc; return {1'b0, r}; end
      OP_MADDU: begin r = ({32'd0, a} * {32'd0, b}) + acc; return {1'b0, r}; end
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (op == OP_DIV) begin
          q  = sa / sb;
          rm = sa % sb;
          return {1'b0, rm[31:0], q[31:0]};
        end
        return {1'b0, a % b, a / b};
      end
      OP_MTHI: return {1'b0, a, acc[31:0]};
      default: return {1'b0, acc[63:32], a};
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] b);
    if (op == OP_MTHI || op == OP_MTLO) return 1;
    if ((op == OP_DIV || op == OP_DIVU) && b == 32'd0) return 1;
    return LONG_LAT;
  endfunction

  // Timeline model: age counts cycles since acceptance, done in cycle 'lat'
  logic        m_active = 1'b0;
  logic        m_busy_op = 1'b0;
  logic [64:0] m_pend = 65'd0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          m_age = 0;
  int          m_lat = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_hi     <= 32'd0;
      m_lo     <= 32'd0;
    end else if (m_active) begin
      if (m_age == m_lat) m_active <= 1'b0;
      else if (flush) m_active <= 1'b0;
      else begin
        m_age <= m_age + 1;
        if (m_age + 1 == m_lat) {m_hi, m_lo} <= m_pend[63:0];
      end
    end else if (req_valid && !flush) begin
      m_pend    <= model_exec(req_op, req_a, req_b, {m_hi, m_lo});
      m_lat     <= model_lat(req_op, req_b);
      m_busy_op <= (req_op != OP_MTHI) && (req_op != OP_MTLO);
      m_active  <= 1'b1;
      m_age     <= 1;
      if (model_lat(req_op, req_b) == 1)
        {m_hi, m_lo} <= model_exec(req_op, req_a, req_b, {m_hi, m_lo}) >> 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check32("hi", hi, m_hi);
      check32("lo", lo, m_lo);
      check1("busy", busy, m_active && m_busy_op);
      check1("done", done, m_active && (m_age == m_lat));
      check1("div_by_zero", div_by_zero, m_active && (m_age == m_lat) && m_pend[64]);
      if (rst_n) check1("req_ready", req_ready, !m_active);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check1("issue_ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = 32'hDEAD_BEEF;
    req_b     = 32'h0BAD_F00D;
    req_op    = OP_MULT;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  int lat;

  initial begin
    clk = 1'b0; rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0;
    req_a = 32'd0; req_b = 32'd0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check32("rst_hi", hi, 32'd0);
    check32("rst_lo", lo, 32'd0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check1("rst_ready", req_ready, 1'b1);

    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done(lat);
    check32("mult_latency", lat, 32'd34);
    check32("mult_hi", hi, 32'hFFFF_FFFF);
    check32("mult_lo", lo, 32'hFFFF_FFEB);

    issue(OP_MTHI, 32'd0, 32'd0);
    wait_done(lat);
    check32("mthi_latency", lat, 32'd1);
    issue(OP_MTLO, 32'd5, 32'd0);
    wait_done(lat);
    check32("mtlo_lo", lo, 32'd5);
    issue(OP_MADDU, 32'hFFFF_FFFF, 32'd2);
    wait_done(lat);
    check32("maddu_hi", hi, 32'h0000_0002);
    check32("maddu_lo", lo, 32'h0000_0003);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat);
    check32("div_lo", lo, 32'hFFFF_FFFD);
    check32("div_hi", hi, 32'hFFFF_FFFF);
    check1("div_dbz", div_by_zero, 1'b0);

    issue(OP_DIVU, 32'd10, 32'd0);
    wait_done(lat);
    check32("divz_latency", lat, 32'd1);
    check32("divz_lo", lo, 32'hFFFF_FFFF);
    check32("divz_hi", hi, 32'd10);
    check1("divz_dbz", div_by_zero, 1'b1);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat);
    check32("divovf_lo", lo, 32'h8000_0000);
    check32("divovf_hi", hi, 32'd0);
    check1("divovf_dbz", div_by_zero, 1'b0);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat);
    check32("multu_max_hi", hi, 32'hFFFF_FFFE);
    check32("multu_max_lo", lo, 32'h0000_0001);

    issue(OP_MULT, 32'd5, 32'd5);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check1("flush_ready", req_ready, 1'b1);
    check32("flush_hi", hi, 32'hFFFF_FFFE);
    check32("flush_lo", lo, 32'h0000_0001);
    repeat (40) @(negedge clk);
    issue(OP_MULTU, 32'd5, 32'd5);
    wait_done(lat);
    check32("multu5_lo", lo, 32'd25);

    @(negedge clk);
    req_valid = 1'b1; req_op = OP_MTHI; req_a = 32'h1234; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check1("flush_acc_ready", req_ready, 1'b1);
    check32("flush_acc_hi", hi, 32'd0);

    issue(OP_MULTU, 32'd3, 32'd4);
    wait_done(lat);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check32("flush_done_lo", lo, 32'd12);

    issue(OP_MADD, 32'hFFFF_FFFE, 32'd3);
    wait_done(lat);
    check32("madd_hi", hi, 32'd0);
    check32("madd_lo", lo, 32'd6);

    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done(lat);
    check32("div_negb_lo", lo, 32'hFFFF_FFFD);
    check32("div_negb_hi", hi, 32'd1);

    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(lat);
    check32("divu_lo", lo, 32'd14);
    check32("divu_hi", hi, 32'd2);

    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check32("mid_rst_hi", hi, 32'd0);
    check32("mid_rst_lo", lo, 32'd0);
    check1("mid_rst_busy", busy, 1'b0);
    check1("mid_rst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(OP_MTLO, 32'd9, 32'd0);
    wait_done(lat);
    check32("post_rst_lo", lo, 32'd9);
    issue(OP_DIVU, 32'd1000, 32'd3);
    wait_done(lat);
    check32("post_rst_div_lo", lo, 32'd333);
    check32("post_rst_div_hi", hi, 32'd1);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide responder for the mini-MIPS datapath; owns the architectural HI/LO registers.
- Executes mult/multu/madd/maddu/div/divu and mthi/mtlo issued by the decode/execute stage. The combinational ALU only handles 32-bit results; all 64-bit and division work comes here.
- Uses a valid/ready request handshake. Issues a one-cycle done pulse when HI/LO are updated; mfhi/mflo read HI/LO continuously.

Parameters:
- XLEN, 32, operand and HI/LO width.
- MUL_ITERS, 32, multiply iterations (one bit per cycle).
- DIV_ITERS, 32, divide iterations (one quotient bit per cycle).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (IDLE state).
- req_op  in  3  operation code; see the package encoding.
- req_a  in  XLEN  rs operand (multiplicand/dividend; source for mthi/mtlo).
- req_b  in  XLEN  rt operand (multiplier/divisor).
- flush  in  1  cancel in-flight operation (branch/exception squash).
- busy  out  1  operation in progress (not IDLE).
- done  out  1  one-cycle pulse in the cycle HI/LO take the new value.
- div_by_zero  out  1  sticky-for-one-cycle flag, valid with done for div/divu.
- hi  out  XLEN  HI register.
- lo  out  XLEN  LO register.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; hi=0, lo=0.
  - req_ready=1 after release; busy=0, done=0, div_by_zero=0.
  - An in-flight operation is discarded.
- Handshake:
  - A request is accepted on a rising edge with req_valid&&req_ready.
  - req_a, req_b and req_op are captured at acceptance and ignored afterward.
  - req_ready=0 from the cycle after acceptance until the cycle after done. There is no back-to-back acceptance in the done cycle.
- mthi/mtlo:
  - Complete in one cycle: hi or lo is written at the acceptance edge, and done=1 in the following cycle.
  - The state stays IDLE.
- Multiply (MULT/MULTU/MADD/MADDU):
  - Signed ops capture absolute values plus a result-sign bit.
  - MUL state: shift-add over a 64-bit product register, one bit per cycle, MUL_ITERS cycles.
  - FIX state (1 cycle): apply the sign by two's-complement negation of the 64-bit product. For MADD/MADDU, also add {hi,lo} captured at acceptance, modulo 2^64 with no overflow flag.
  - DONE state (1 cycle): hi/lo written, done=1, back to IDLE.
  - Total: acceptance at edge 0, done high during cycle 34.
- Divide (DIV/DIVU):
  - DIV state: restoring division on magnitudes, DIV_ITERS cycles.
  - FIX: quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - Outputs: lo=quotient, hi=remainder. Same latency as multiply.
- Boundary cases:
  - Divisor 0: skip iteration, go to DONE in the cycle after acceptance. lo=32'hFFFF_FFFF, hi=req_a, div_by_zero=1 with done.
  - DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0, no flag (falls out of the magnitude math; must be verified).
  - MULTU 0xFFFF_FFFF * 0xFFFF_FFFF: {hi,lo}=0xFFFF_FFFE_0000_0001.
- Flush:
  - When busy, flush returns to IDLE on the next edge with HI/LO unchanged and no done pulse.
  - flush in IDLE is ignored; flush concurrent with acceptance accepts nothing.
  - flush in the DONE cycle is too late: the write and done occur.
- Reserved op code: accepted, no HI/LO change, done pulses the next cycle.

Decomposition:
- Shared package (muldiv_defs, `include or package): 3-bit op encoding.
  - OP_MULT=0, OP_MULTU=1, OP_MADD=2, OP_MADDU=3, OP_DIV=4, OP_DIVU=5, OP_MTHI=6, OP_MTLO=7.
  - State encodings IDLE/MUL/DIV/FIX/DONE.
  - The ITERS defaults.
- One natural sub-module: muldiv_datapath. It holds the 64-bit shift register, the iteration counter, the add/subtract step, and sign correction. muldiv_unit keeps the FSM, handshake and HI/LO.

Test Plan:
- Signed multiply: reset, then MULT a=-3 (0xFFFF_FFFD), b=7.
  - Expect req_ready=0 for 34 cycles.
  - Expect done in cycle 34 with hi=0xFFFF_FFFF, lo=0xFFFF_FFEB.
- Multiply-accumulate: MTHI 0, MTLO 5, then MADDU a=0xFFFF_FFFF, b=2.
  - Expect {hi,lo}=0x0000_0002_0000_0003.
- Signed divide: DIV a=-7, b=2.
  - Expect lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1), div_by_zero=0.
- Divide edge cases:
  - DIVU a=10, b=0: expect done on the next cycle, lo=0xFFFF_FFFF, hi=10, div_by_zero=1.
  - DIV 0x8000_0000 / -1: expect lo=0x8000_0000, hi=0.
- Flush: MULT 5*5, then assert flush at cycle 10.
  - Expect no done, hi/lo unchanged, req_ready=1 the next cycle.
  - A following MULTU 5*5 gives lo=25.
- Reset mid-operation: drop rst_n at cycle 20 of DIVU.
  - Expect immediate hi=lo=0, busy=0, no done.
  - After release, a new request is accepted.
